// File: rtl/uart_tick_gen_mc_if.sv
// uart_tick_gen_mc_if: scaler write port of the multi-channel tick generator.
// valid/ready handshake; chan selects the channel, scaler carries the value.
interface uart_tick_gen_mc_if #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned SCALER_WIDTH = 16
);
  localparam int unsigned CW = $clog2(CHANNELS) + 1;

  logic                    i_wr_valid;
  logic                    o_wr_ready;
  logic [CW-1:0]           i_wr_chan;
  logic [SCALER_WIDTH-1:0] i_wr_scaler;

  modport master (
    output i_wr_valid,
    output i_wr_chan,
    output i_wr_scaler,
    input  o_wr_ready
  );

  modport slave (
    input  i_wr_valid,
    input  i_wr_chan,
    input  i_wr_scaler,
    output o_wr_ready
  );
endinterface

// File: rtl/uart_tick_gen_mc.sv
// uart_tick_gen_mc: per-channel programmable baud/oversample tick generator.
// Ports: i_clk/i_rst (sync, active-high), wr (scaler write port, slave),
//   i_restart (per-channel restart), o_tick, o_half_tick, o_active, o_err.
module uart_tick_gen_mc #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned SCALER_WIDTH  = 16,
  parameter int unsigned SPEED_UP_RATE = 0,
  parameter int unsigned RESET_SCALER  = 0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  uart_tick_gen_mc_if.slave   wr,
  input  logic [CHANNELS-1:0] i_restart,
  output logic [CHANNELS-1:0] o_tick,
  output logic [CHANNELS-1:0] o_half_tick,
  output logic [CHANNELS-1:0] o_active,
  output logic                o_err
);
  localparam int unsigned CW = $clog2(CHANNELS) + 1;
  localparam int unsigned SW = SCALER_WIDTH;

  logic [SW-1:0] scaler_q [CHANNELS];
  logic [SW-1:0] scaler_d [CHANNELS];
  logic [SW-1:0] shadow_q [CHANNELS];
  logic [SW-1:0] shadow_d [CHANNELS];
  logic [SW-1:0] cnt_q    [CHANNELS];
  logic [SW-1:0] cnt_d    [CHANNELS];

  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] tick_q, tick_d;
  logic [CHANNELS-1:0] half_q, half_d;
  logic                err_q, err_d;
  logic                rdy, chan_ok;

  // eff = max(1, scaler >> SPEED_UP_RATE)
  function automatic logic [SW-1:0] eff_of(
    input logic [SW-1:0] s
  );
    logic [SW-1:0] e;
    e = s >> SPEED_UP_RATE;
    return (e == '0) ? SW'(1) : e;
  endfunction

  always_comb begin
    rdy     = 1'b1;
    chan_ok = 1'b0;
    for (int n = 0; n < CHANNELS; n++) begin
      if (wr.i_wr_chan == CW'(n)) begin
        rdy     = ~pend_q[n];
        chan_ok = 1'b1;
      end
    end
  end

  assign wr.o_wr_ready = rdy;

  always_comb begin
    logic [SW-1:0] last;
    logic          wrap;
    err_d  = err_q | (wr.i_wr_valid & ~chan_ok);
    pend_d = pend_q;
    tick_d = '0;
    half_d = '0;
    last   = '0;
    wrap   = 1'b0;
    for (int n = 0; n < CHANNELS; n++) begin
      scaler_d[n] = scaler_q[n];
      shadow_d[n] = shadow_q[n];
      cnt_d[n]    = cnt_q[n];
      last        = eff_of(scaler_q[n]) - SW'(1);
      wrap        = (cnt_q[n] == last);
      // accept only when idle, so it never races an apply
      if (wr.i_wr_valid && !pend_q[n] &&
          wr.i_wr_chan == CW'(n)) begin
        shadow_d[n] = wr.i_wr_scaler;
        pend_d[n]   = 1'b1;
      end
      if (i_restart[n] || scaler_q[n] == '0) begin
        cnt_d[n] = '0;
        if (pend_q[n]) begin
          scaler_d[n] = shadow_q[n];
          pend_d[n]   = 1'b0;
        end
      end else begin
        tick_d[n] = wrap;
        half_d[n] = (cnt_q[n] == (last >> 1));
        if (wrap) begin
          cnt_d[n] = '0;
          if (pend_q[n]) begin
            scaler_d[n] = shadow_q[n];
            pend_d[n]   = 1'b0;
          end
        end else begin
          cnt_d[n] = cnt_q[n] + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int n = 0; n < CHANNELS; n++) begin
        scaler_q[n] <= SW'(RESET_SCALER);
        shadow_q[n] <= '0;
        cnt_q[n]    <= '0;
      end
      pend_q <= '0;
      tick_q <= '0;
      half_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        scaler_q[n] <= scaler_d[n];
        shadow_q[n] <= shadow_d[n];
        cnt_q[n]    <= cnt_d[n];
      end
      pend_q <= pend_d;
      tick_q <= tick_d;
      half_q <= half_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    for (int n = 0; n < CHANNELS; n++)
      o_active[n] = (scaler_q[n] != '0);
  end

  assign o_tick      = tick_q;
  assign o_half_tick = half_q;
  assign o_err       = err_q;
endmodule

// File: tb/tb_uart_tick_gen_mc.sv
// tb_uart_tick_gen_mc: directed bench for uart_tick_gen_mc.
// SPEED_UP_RATE=3, four channels, channels disabled out of reset.
module tb_uart_tick_gen_mc;
  localparam int CH = 4;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] restart;
  logic [CH-1:0] tick, half, active;
  logic          err;

  int n_asrt = 0;
  int n_fail = 0;
  int cnt;

  uart_tick_gen_mc_if #(
    .CHANNELS(CH), .SCALER_WIDTH(SW)
  ) wr_if ();

  uart_tick_gen_mc #(
    .CHANNELS(CH), .SCALER_WIDTH(SW),
    .SPEED_UP_RATE(3), .RESET_SCALER(0)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .wr(wr_if.slave),
    .i_restart(restart),
    .o_tick(tick),
    .o_half_tick(half),
    .o_active(active),
    .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycn(input int k);
    for (int i = 0; i < k; i++) cyc();
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // cycles until the chosen strobe of channel ch is seen (bounded)
  task automatic meas(
    input  int ch,
    input  bit use_half,
    output int n
  );
    n = 0;
    do begin
      cyc();
      n++;
    end while (!(use_half ? half[ch] : tick[ch]) && n < 64);
  endtask

  task automatic put(
    input logic [2:0]    ch,
    input logic [SW-1:0] v
  );
    wr_if.i_wr_valid  = 1'b1;
    wr_if.i_wr_chan   = ch;
    wr_if.i_wr_scaler = v;
  endtask

  initial begin
    rst = 1'b1;
    restart = '0;
    wr_if.i_wr_valid  = 1'b0;
    wr_if.i_wr_chan   = '0;
    wr_if.i_wr_scaler = '0;
    cycn(2);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_half", 32'(half), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ready", 32'(wr_if.o_wr_ready), 1);
    rst = 1'b0;

    // 1: ch0 80>>3 = 10
    put(0, 80);
    cyc();
    chk("t1_ready_low", 32'(wr_if.o_wr_ready), 0);
    wr_if.i_wr_valid = 1'b0;
    cyc();
    chk("t1_active", 32'(active[0]), 1);
    meas(0, 1, cnt); chk("t1_half_ofs", cnt, 5);
    meas(0, 0, cnt); chk("t1_tick_ofs", cnt, 5);
    meas(0, 0, cnt); chk("t1_period", cnt, 10);
    meas(0, 1, cnt); chk("t1_half_after", cnt, 5);

    // 2: ch1 4>>3 = 0 -> clamped to 1
    put(1, 4);
    cyc();
    wr_if.i_wr_valid = 1'b0;
    cyc();
    chk("t2_active", 32'(active[1]), 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t2_tick_every", 32'(tick[1]), 1);
      chk("t2_half_every", 32'(half[1]), 1);
    end

    // 3: rewrite 160 at cnt=3
    wr_if.i_wr_chan = 0;
    meas(0, 0, cnt);
    cycn(3);
    put(0, 160);
    #1;
    chk("t3_ready_pre", 32'(wr_if.o_wr_ready), 1);
    cyc();
    chk("t3_ready_low", 32'(wr_if.o_wr_ready), 0);
    wr_if.i_wr_valid = 1'b0;
    meas(0, 0, cnt); chk("t3_old_spacing", cnt, 6);
    chk("t3_ready_back", 32'(wr_if.o_wr_ready), 1);
    meas(0, 0, cnt); chk("t3_new_period", cnt, 20);

    // 4: write to non-existent channel 4
    put(4, 8);
    #1;
    chk("t4_ready", 32'(wr_if.o_wr_ready), 1);
    cyc();
    chk("t4_err", 32'(err), 1);
    chk("t4_active", 32'(active), 32'h3);
    wr_if.i_wr_valid = 1'b0;
    wr_if.i_wr_chan  = 0;
    meas(0, 0, cnt); chk("t4_ch0_period", cnt, 19);
    chk("t4_err_sticky", 32'(err), 1);

    // back to eff=10 on ch0
    put(0, 80);
    cyc();
    wr_if.i_wr_valid = 1'b0;
    meas(0, 0, cnt); chk("t5_prep_old", cnt, 19);
    meas(0, 0, cnt); chk("t5_prep_new", cnt, 10);

    // 5a: restart at cnt==9 suppresses the tick
    cycn(9);
    restart[0] = 1'b1;
    cyc();
    restart[0] = 1'b0;
    chk("t5_tick_supp", 32'(tick[0]), 0);
    meas(0, 0, cnt); chk("t5_after_rst", cnt, 10);

    // 5b: restart applies pending shadow at once
    put(0, 160);
    cyc();
    wr_if.i_wr_valid = 1'b0;
    chk("t5_pend", 32'(wr_if.o_wr_ready), 0);
    cycn(4);
    restart[0] = 1'b1;
    cyc();
    restart[0] = 1'b0;
    chk("t5_applied", 32'(wr_if.o_wr_ready), 1);
    meas(0, 0, cnt); chk("t5_new_period", cnt, 20);

    // writing 0 disables ch1 at its period end
    put(1, 0);
    cyc();
    wr_if.i_wr_valid = 1'b0;
    cyc();
    chk("dis_active", 32'(active[1]), 0);
    cycn(2);
    chk("dis_tick", 32'(tick[1]), 0);

    // 6: reset mid-period with pending set
    cycn(3);
    put(0, 80);
    cyc();
    wr_if.i_wr_valid = 1'b0;
    rst = 1'b1;
    cyc();
    chk("t6_tick", 32'(tick), 0);
    chk("t6_half", 32'(half), 0);
    chk("t6_active", 32'(active), 0);
    chk("t6_err", 32'(err), 0);
    chk("t6_ready", 32'(wr_if.o_wr_ready), 1);
    rst = 1'b0;
    cycn(15);
    chk("t6_active_post", 32'(active), 0);
    chk("t6_tick_post", 32'(tick), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end
endmodule
